dma_read_arbiter: RTL and testbench

DMA_READ_ARBITER -- requirements
Module: dma_read_arbiter

---
 rtl/dma_read_arbiter_pkg.sv | 20 ++
 rtl/dma_read_arbiter_if.sv | 37 +++
 rtl/dma_read_arbiter_rr_priority_picker.sv | 27 ++
 rtl/dma_read_arbiter.sv | 131 +++++++++++++
 tb/tb_dma_read_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_read_arbiter_pkg.sv
// Shared constants for the DMA read arbiter: bus widths, default sizing and
// the FSM state encoding.
package dma_read_arbiter_pkg;

    localparam int DEF_REQUESTERS      = 4;
    localparam int DEF_MAX_OUTSTANDING = 8;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 10;
    localparam int TAG_W  = 8;
    localparam int ID_W   = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dma_read_arbiter_if.sv
// Requester, TLP-requester and status signals of the DMA read arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface dma_read_arbiter_if #(
    parameter int P_REQUESTERS = dma_read_arbiter_pkg::DEF_REQUESTERS
);
    import dma_read_arbiter_pkg::*;

    logic [ADDR_W*P_REQUESTERS-1:0] req_addr;
    logic [LEN_W*P_REQUESTERS-1:0]  req_len;
    logic [P_REQUESTERS-1:0]        req_valid;
    logic [P_REQUESTERS-1:0]        req_done;
    logic [TAG_W-1:0]               req_tag;

    logic [ADDR_W-1:0]              mst_addr;
    logic [LEN_W-1:0]               mst_len;
    logic                           mst_valid;
    logic                           mst_done;
    logic [TAG_W-1:0]               mst_tag;

    logic                           cpl_release;
    logic [CNT_W-1:0]               outstanding;
    logic [ID_W-1:0]                grant_id;
    logic                           err_underflow;

    modport slave (
        input  req_addr, req_len, req_valid, mst_done, mst_tag, cpl_release,
        output req_done, req_tag, mst_addr, mst_len, mst_valid,
               outstanding, grant_id, err_underflow
    );

    modport master (
        output req_addr, req_len, req_valid, mst_done, mst_tag, cpl_release,
        input  req_done, req_tag, mst_addr, mst_len, mst_valid,
               outstanding, grant_id, err_underflow
    );

endinterface

// File: rtl/dma_read_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from last_i+1 with wrap-around.
module rr_priority_picker
    import dma_read_arbiter_pkg::*;
#(
    parameter int P_REQUESTERS = DEF_REQUESTERS
) (
    input  logic [P_REQUESTERS-1:0] req_i,
    input  logic [ID_W-1:0]         last_i,
    output logic [ID_W-1:0]         winner_o,
    output logic                    any_o
);

    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned; that is what keeps this block free of latches.
    always_comb begin
        winner_o = last_i;
        any_o    = |req_i;
        // Walk from the farthest offset to the nearest; the nearest hit wins.
        for (int k = P_REQUESTERS; k >= 1; k--) begin
            int idx;
            idx = (int'(last_i) + k) % P_REQUESTERS;
            if (req_i[idx]) winner_o = ID_W'(idx);
        end
    end

endmodule

// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter feeding DMA read requests to a single TLP requester,
// with a cap on requests in flight awaiting completion.
module dma_read_arbiter
    import dma_read_arbiter_pkg::*;
#(
    parameter int P_REQUESTERS      = DEF_REQUESTERS,
    parameter int P_MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input logic               i_clk,
    input logic               i_rst_n,
    dma_read_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mst_addr_q, mst_addr_d;
    logic [LEN_W-1:0]  mst_len_q, mst_len_d;
    logic              mst_valid_q, mst_valid_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic              err_q, err_d;

    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              accept;
    logic              can_grant;
    logic [ADDR_W-1:0] win_addr;
    logic [LEN_W-1:0]  win_len;

    rr_priority_picker #(.P_REQUESTERS(P_REQUESTERS)) u_picker (
        .req_i   (bus.req_valid),
        .last_i  (grant_q),
        .winner_o(winner),
        .any_o   (any_valid)
    );

    assign accept    = (state_q == ST_ISSUE) && bus.mst_done;
    assign can_grant = any_valid && (out_q < CNT_W'(P_MAX_OUTSTANDING));

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int k = 0; k < P_REQUESTERS; k++) begin
            if (winner == ID_W'(k)) begin
                win_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
                win_len  = bus.req_len[k*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mst_addr_d  = mst_addr_q;
        mst_len_d   = mst_len_q;
        mst_valid_d = mst_valid_q;
        grant_d     = grant_q;
        tag_d       = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (can_grant) begin
                    state_d     = ST_ISSUE;
                    mst_addr_d  = win_addr;
                    mst_len_d   = win_len;
                    mst_valid_d = 1'b1;
                    grant_d     = winner;
                end
            end
            ST_ISSUE: begin
                if (bus.mst_done) begin
                    state_d     = ST_RELEASE;
                    tag_d       = bus.mst_tag;
                    mst_valid_d = 1'b0;
                end
            end
            // One dead cycle lets the served requester drop valid before
            // the next search.
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        err_d = err_q | (bus.cpl_release && (out_q == '0));
        case ({accept, bus.cpl_release})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   if (out_q != '0) out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            mst_addr_q  <= '0;
            mst_len_q   <= '0;
            mst_valid_q <= 1'b0;
            grant_q     <= ID_W'(P_REQUESTERS - 1);
            tag_q       <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mst_addr_q  <= mst_addr_d;
            mst_len_q   <= mst_len_d;
            mst_valid_q <= mst_valid_d;
            grant_q     <= grant_d;
            tag_q       <= tag_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        bus.req_done = '0;
        for (int k = 0; k < P_REQUESTERS; k++) begin
            bus.req_done[k] = accept && (grant_q == ID_W'(k));
        end
    end

    assign bus.req_tag       = tag_q;
    assign bus.mst_addr      = mst_addr_q;
    assign bus.mst_len       = mst_len_q;
    assign bus.mst_valid     = mst_valid_q;
    assign bus.outstanding   = out_q;
    assign bus.grant_id      = grant_q;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Bench for dma_read_arbiter: transaction-level model compared every cycle on
// the default instance, plus directed checks including a 2-deep instance.
module tb_dma_read_arbiter;
    import dma_read_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 8;
    localparam int MAXL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_read_arbiter_if #(.P_REQUESTERS(N)) bus ();
    dma_read_arbiter_if #(.P_REQUESTERS(N)) bus_l ();

    dma_read_arbiter #(.P_REQUESTERS(N), .P_MAX_OUTSTANDING(MAXO)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    dma_read_arbiter #(.P_REQUESTERS(N), .P_MAX_OUTSTANDING(MAXL)) dut_l (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_l.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: one request in flight to the TLP requester, one
    // idle cycle after each acceptance, round-robin among valid requesters.
    bit          m_busy, m_cool, m_err, m_acc, m_found;
    int          m_last, m_from, m_k, m_out;
    logic [31:0] m_addr;
    logic [9:0]  m_len;
    logic [7:0]  m_tag;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_cool = 0; m_err = 0;
            m_last = N - 1; m_out = 0;
            m_addr = '0; m_len = '0; m_tag = '0;
        end else begin
            m_acc = m_busy && bus.mst_done;
            if (bus.cpl_release && m_out == 0) m_err = 1;
            if (m_acc) begin
                m_tag  = bus.mst_tag;
                m_busy = 0;
                m_cool = 1;
            end else if (m_cool) begin
                m_cool = 0;
            end else if (!m_busy && m_out < MAXO) begin
                m_found = 0;
                m_from  = m_last;
                for (int s = 1; s <= N; s++) begin
                    m_k = (m_from + s) % N;
                    if (!m_found && bus.req_valid[m_k]) begin
                        m_found = 1;
                        m_last  = m_k;
                        m_addr  = bus.req_addr[m_k*32 +: 32];
                        m_len   = bus.req_len[m_k*10 +: 10];
                        m_busy  = 1;
                    end
                end
            end
            m_out = m_out + (m_acc ? 1 : 0) - (bus.cpl_release ? 1 : 0);
            if (m_out < 0) m_out = 0;
        end
    end

    always @(negedge clk) begin
        check("mst_valid", bus.mst_valid, m_busy);
        check("mst_addr", bus.mst_addr, m_addr);
        check("mst_len", bus.mst_len, m_len);
        check("grant_id", bus.grant_id, m_last);
        check("req_tag", bus.req_tag, m_tag);
        check("outstanding", bus.outstanding, m_out);
        check("err_underflow", bus.err_underflow, m_err);
        check("req_done", bus.req_done, (m_busy && bus.mst_done) ? (64'd1 << m_last) : 64'd0);
    end

    int done_cnt[N];
    initial for (int k = 0; k < N; k++) done_cnt[k] = 0;
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) if (bus.req_done[k]) done_cnt[k]++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int          order[5];
    int          rise[5];
    int          cyc;
    int          waited;
    int          cnt3;
    logic [3:0]  vl, dn, acc_mask;

    initial begin
        bus.req_addr = '0; bus.req_len = '0; bus.req_valid = '0;
        bus.mst_done = 0; bus.mst_tag = '0; bus.cpl_release = 0;
        bus_l.req_addr = '0; bus_l.req_len = '0; bus_l.req_valid = '0;
        bus_l.mst_done = 0; bus_l.mst_tag = '0; bus_l.cpl_release = 0;

        // Reset state
        tick(); tick();
        check("rst grant_id", bus.grant_id, 3);
        check("rst outstanding", bus.outstanding, 0);
        check("rst mst_valid", bus.mst_valid, 0);
        rst_n = 1;
        tick();

        // Single requester, done three cycles after valid
        bus.req_addr[31:0] = 32'h1000_0000;
        bus.req_len[9:0]   = 10'd32;
        bus.req_valid      = 4'b0001;
        #1 check("A no valid before edge", bus.mst_valid, 0);
        tick();
        check("A mst_valid latency", bus.mst_valid, 1);
        check("A mst_addr", bus.mst_addr, 32'h1000_0000);
        check("A mst_len", bus.mst_len, 32);
        tick(); tick();
        bus.mst_done = 1; bus.mst_tag = 8'h05;
        #1 check("A req_done comb", bus.req_done, 4'b0001);
        tick();
        bus.mst_done = 0; bus.req_valid = 4'b0000;
        check("A req_tag", bus.req_tag, 8'h05);
        check("A outstanding", bus.outstanding, 1);
        check("A mst_valid cleared", bus.mst_valid, 0);
        tick(); tick(); tick();
        check("A done pulses", done_cnt[0], 1);

        // Acceptance and release together leave the count unchanged
        bus.req_addr[95:64] = 32'h2000_0040;
        bus.req_len[29:20]  = 10'd16;
        bus.req_valid       = 4'b0100;
        tick();
        check("B grant_id", bus.grant_id, 2);
        bus.mst_done = 1; bus.mst_tag = 8'h11; bus.cpl_release = 1;
        tick();
        bus.mst_done = 0; bus.cpl_release = 0; bus.req_valid = 4'b0000;
        check("B outstanding", bus.outstanding, 1);
        check("B req_tag", bus.req_tag, 8'h11);

        // Release to zero, then underflow
        bus.cpl_release = 1;
        tick();
        bus.cpl_release = 0;
        check("C outstanding", bus.outstanding, 0);
        check("C no err", bus.err_underflow, 0);
        bus.cpl_release = 1;
        tick();
        bus.cpl_release = 0;
        check("C underflow count", bus.outstanding, 0);
        check("C underflow err", bus.err_underflow, 1);
        tick(); tick();
        check("C err sticky", bus.err_underflow, 1);
        rst_n = 0;
        #1 check("C err cleared by reset", bus.err_underflow, 0);
        tick();
        rst_n = 1;
        tick();

        // All requesters valid, done held high
        for (int k = 0; k < N; k++) begin
            bus.req_addr[k*32 +: 32] = 32'h3000_0000 + 32'(k) * 32'h100;
            bus.req_len[k*10 +: 10]  = 10'(k + 1);
        end
        bus.mst_tag = 8'h20; bus.mst_done = 1; bus.req_valid = 4'b1111;
        cyc = 0;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            do begin
                tick(); cyc++; waited++;
            end while (!bus.mst_valid && waited < 10);
            check("D grant seen", bus.mst_valid, 1);
            check("D mst_addr", bus.mst_addr, 32'h3000_0000 + 32'(g % 4) * 32'h100);
            order[g] = int'(bus.grant_id);
            rise[g]  = cyc;
        end
        tick();
        bus.mst_done = 0; bus.req_valid = 4'b0000;
        for (int g = 0; g < 5; g++) check("D grant order", order[g], g % 4);
        for (int g = 1; g < 5; g++) check("D grant spacing", rise[g] - rise[g-1], 3);
        check("D outstanding", bus.outstanding, 5);
        tick(); tick();

        // Reset while a request is being presented
        bus.req_valid = 4'b1000;
        tick();
        check("E grant_id", bus.grant_id, 3);
        cnt3 = done_cnt[3];
        bus.mst_done = 1;
        rst_n = 0;
        #1;
        check("E mst_valid in reset", bus.mst_valid, 0);
        check("E req_done in reset", bus.req_done, 0);
        tick();
        bus.mst_done = 0; bus.req_valid = 4'b1111;
        check("E no done after reset", done_cnt[3], cnt3);
        rst_n = 1;
        tick();
        check("E first grant valid", bus.mst_valid, 1);
        check("E first grant to 0", bus.grant_id, 0);
        bus.mst_done = 1;
        tick();
        bus.mst_done = 0; bus.req_valid = 4'b0000;
        tick(); tick();

        // Limited instance: two in flight, third held until a release
        for (int k = 0; k < 3; k++) begin
            bus_l.req_addr[k*32 +: 32] = 32'h4000_0000 + 32'(k) * 32'h40;
            bus_l.req_len[k*10 +: 10]  = 10'd8;
        end
        bus_l.mst_done = 1; bus_l.mst_tag = 8'h33;
        vl = 4'b0111; acc_mask = '0;
        bus_l.req_valid = vl;
        for (int c = 0; c < 12; c++) begin
            dn = bus_l.req_done;
            tick();
            vl       = vl & ~dn;
            acc_mask = acc_mask | dn;
            bus_l.req_valid = vl;
        end
        check("F accepted", acc_mask, 4'b0011);
        check("F outstanding at cap", bus_l.outstanding, 2);
        check("F held", bus_l.mst_valid, 0);
        bus_l.cpl_release = 1;
        tick();
        bus_l.cpl_release = 0;
        check("F after release count", bus_l.outstanding, 1);
        check("F not yet granted", bus_l.mst_valid, 0);
        tick();
        check("F resumed", bus_l.mst_valid, 1);
        check("F grant_id", bus_l.grant_id, 2);
        check("F mst_addr", bus_l.mst_addr, 32'h4000_0080);
        tick();
        bus_l.mst_done = 0; bus_l.req_valid = 4'b0000;
        check("F outstanding final", bus_l.outstanding, 2);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
